// File: rtl/cache_way_array.sv
// N-way set-associative line storage with valid/dirty bits, per-set true-LRU
// ages and a multi-cycle flush sweep that invalidates every set.
module cache_way_array #(
  parameter int WIDTH = 128,
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  localparam int IW   = $clog2(SETS),
  localparam int AW   = $clog2(WAYS),
  localparam int BW   = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IW-1:0]    index,
  input  logic [AW-1:0]    way_sel,
  input  logic             write,
  input  logic [BW-1:0]    byte_en,
  input  logic [WIDTH-1:0] datain,
  input  logic             set_dirty,
  input  logic             touch,
  input  logic             flush_req,
  output logic [WIDTH-1:0] dataout,
  output logic [WAYS-1:0]  valid_out,
  output logic [WAYS-1:0]  dirty_out,
  output logic [AW-1:0]    lru_way,
  output logic             flush_busy,
  output logic             flush_done
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [WIDTH-1:0] r_data  [WAYS][SETS];
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAYS-1:0]  r_dirty [SETS];
  logic [AW-1:0]    r_age   [SETS][WAYS];
  logic [0:0]       r_state;
  logic [IW-1:0]    r_cnt;
  logic             r_done;

  logic             w_idle;
  logic             w_wr;
  logic [AW-1:0]    w_old;
  logic [AW-1:0]    w_age_new [WAYS];
  logic [AW-1:0]    w_lru;

  assign w_idle = (r_state == S_IDLE);
  assign w_wr   = w_idle & write & ~flush_req;
  assign w_old  = r_age[index][way_sel];

  // Touched way becomes MRU; ways younger than it age by one.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_age_new[w] = r_age[index][w];
      if (way_sel == AW'(w))
        w_age_new[w] = '0;
      else if (r_age[index][w] < w_old)
        w_age_new[w] = r_age[index][w] + AW'(1);
    end
  end

  always_comb begin
    w_lru = '0;
    for (int w = 0; w < WAYS; w++)
      if (r_age[index][w] == AW'(WAYS - 1))
        w_lru = AW'(w);
  end

  // Line data carries no reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BW; b++)
      if (w_wr && byte_en[b])
        r_data[way_sel][index][8*b +: 8] <= datain[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++)
          r_age[s][w] <= AW'(WAYS - 1 - w);
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush_req) begin
            r_state <= S_FLUSH;
            r_cnt   <= '0;
          end else if (write || touch) begin
            if (write) begin
              r_valid[index][way_sel] <= 1'b1;
              if (set_dirty)
                r_dirty[index][way_sel] <= 1'b1;
            end
            for (int w = 0; w < WAYS; w++)
              r_age[index][w] <= w_age_new[w];
          end
        end
        S_FLUSH: begin
          r_valid[r_cnt] <= '0;
          r_dirty[r_cnt] <= '0;
          for (int w = 0; w < WAYS; w++)
            r_age[r_cnt][w] <= AW'(WAYS - 1 - w);
          if (r_cnt == IW'(SETS - 1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + IW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dataout    = r_data[way_sel][index];
  assign valid_out  = r_valid[index];
  assign dirty_out  = r_dirty[index];
  assign lru_way    = w_lru;
  assign flush_busy = (r_state == S_FLUSH);
  assign flush_done = r_done;

endmodule

// File: tb/tb_cache_way_array.sv
// Directed scoreboard bench for cache_way_array (2-way and 4-way instances).
module tb_cache_way_array;

  typedef struct {
    string        tag;
    logic [127:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic         clk = 0;
  logic         rst_n;
  logic [2:0]   index;
  logic [1:0]   way_sel;
  logic         write;
  logic [15:0]  byte_en;
  logic [127:0] datain;
  logic         set_dirty;
  logic         touch;
  logic         flush_req;

  logic [127:0] d2_data;
  logic [1:0]   d2_valid;
  logic [1:0]   d2_dirty;
  logic         d2_lru;
  logic         d2_busy;
  logic         d2_done;

  logic [127:0] d4_data;
  logic [3:0]   d4_valid;
  logic [3:0]   d4_dirty;
  logic [1:0]   d4_lru;
  logic         d4_busy;
  logic         d4_done;

  always #5 clk = ~clk;

  cache_way_array #(.WIDTH(128), .SETS(8), .WAYS(2)) dut (
    .clk(clk), .rst_n(rst_n), .index(index), .way_sel(way_sel[0]),
    .write(write), .byte_en(byte_en), .datain(datain),
    .set_dirty(set_dirty), .touch(touch), .flush_req(flush_req),
    .dataout(d2_data), .valid_out(d2_valid), .dirty_out(d2_dirty),
    .lru_way(d2_lru), .flush_busy(d2_busy), .flush_done(d2_done)
  );

  cache_way_array #(.WIDTH(128), .SETS(8), .WAYS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .index(index), .way_sel(way_sel),
    .write(write), .byte_en(byte_en), .datain(datain),
    .set_dirty(set_dirty), .touch(touch), .flush_req(flush_req),
    .dataout(d4_data), .valid_out(d4_valid), .dirty_out(d4_dirty),
    .lru_way(d4_lru), .flush_busy(d4_busy), .flush_done(d4_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input int s, input int w);
    index   = 3'(s);
    way_sel = 2'(w);
    #1;
  endtask

  task automatic push(input string t, input logic [127:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop(input logic [127:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed %0h with no expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (d2_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    rst_n = 0; index = 0; way_sel = 0; write = 0; byte_en = 0;
    datain = 0; set_dirty = 0; touch = 0; flush_req = 0;
    repeat (2) tick();

    for (int s = 0; s < 8; s++) begin
      push($sformatf("rst_valid_s%0d", s), 0);
      push($sformatf("rst_dirty_s%0d", s), 0);
      push($sformatf("rst_lru_s%0d", s), 0);
      look(s, 0);
      pop(d2_valid); pop(d2_dirty); pop(d2_lru);
    end
    push("rst_busy", 0); pop(d2_busy);
    push("rst_done", 0); pop(d2_done);
    push("rst_lru4", 0); pop(d4_lru);
    rst_n = 1;
    tick();

    // clean line write, not dirty
    index = 3; way_sel = 1; byte_en = '1; datain = 0; write = 1;
    push("zw_valid", 2'b10); push("zw_dirty", 0); push("zw_data", 0);
    tick();
    write = 0;
    pop(d2_valid); pop(d2_dirty); pop(d2_data);

    // partial byte write with dirty
    datain = {16{8'hA5}}; byte_en = 16'h00FF; set_dirty = 1; write = 1;
    push("bw_data", {64'h0, {8{8'hA5}}});
    push("bw_valid", 2'b10); push("bw_dirty", 2'b10); push("bw_lru", 0);
    tick();
    write = 0; set_dirty = 0;
    pop(d2_data); pop(d2_valid); pop(d2_dirty); pop(d2_lru);

    // 4-way LRU sequence in set 0
    index = 0;
    push("lru4_all", 0);
    for (int w = 0; w < 4; w++) begin
      way_sel = 2'(w); touch = 1;
      tick();
    end
    touch = 0;
    pop(d4_lru);
    push("lru4_t0", 1);
    way_sel = 0; touch = 1; tick(); touch = 0;
    pop(d4_lru);
    push("lru4_t0_again", 1);
    touch = 1; tick(); touch = 0;
    pop(d4_lru);

    // write+touch together, byte_en all zero
    index = 5; way_sel = 0; write = 1; touch = 1; byte_en = 0;
    push("wt_valid", 2'b01); push("wt_lru", 1); push("wt_lru4", 1);
    tick();
    write = 0; touch = 0;
    pop(d2_valid); pop(d2_lru); pop(d4_lru);

    for (int s = 0; s < 8; s++) begin
      index = 3'(s); way_sel = 0; write = 1; byte_en = '1;
      datain = 128'(s);
      tick();
    end
    write = 0;
    push("fill_v7", 2'b01); look(7, 0); pop(d2_valid);
    push("fill_v3", 2'b11); look(3, 0); pop(d2_valid);

    flush_req = 1;
    tick();
    flush_req = 0;
    push("fl_busy0", 1); pop(d2_busy);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        index = 7; way_sel = 1; write = 1; byte_en = '1;
      end
      tick();
      write = 0;
      push($sformatf("fl_clr_s%0d", k), 0);
      look(k, 0);
      pop(d2_valid);
      if (k < 7) begin
        push($sformatf("fl_busy_k%0d", k), 1); pop(d2_busy);
        push($sformatf("fl_v7_k%0d", k), 2'b01);
        look(7, 0);
        pop(d2_valid);
      end
    end
    push("fl_end_busy", 0); pop(d2_busy);
    push("fl_done", 1); pop(d2_done);
    tick();
    push("fl_done_pulse", 0); pop(d2_done);
    push("fl_lru_s5", 0); look(5, 0); pop(d2_lru);
    push("fl_dirty_s3", 0); look(3, 0); pop(d2_dirty);

    // flush and write on the same edge
    index = 2; way_sel = 0; write = 1; byte_en = '1; flush_req = 1;
    tick();
    write = 0; flush_req = 0;
    push("fw_busy", 1); pop(d2_busy);
    push("fw_cycles", 8);
    wait_done(n);
    pop(n);
    push("fw_valid", 0); look(2, 0); pop(d2_valid);

    // flush_req held at flush_done restarts the sweep
    flush_req = 1;
    tick();
    flush_req = 0;
    push("re_busy", 1); pop(d2_busy);
    push("re_done_seen", 1);
    wait_done(n);
    pop(d2_done);

    // async reset mid-flush
    tick();
    index = 6; way_sel = 0; write = 1; byte_en = '1;
    tick();
    write = 0;
    flush_req = 1;
    tick();
    flush_req = 0;
    repeat (4) tick();
    push("ar_pre_busy", 1); pop(d2_busy);
    #2;
    rst_n = 0;
    #1;
    push("ar_busy", 0); push("ar_done", 0); push("ar_valid", 0);
    pop(d2_busy); pop(d2_done); pop(d2_valid);
    tick();
    push("ar_done_hold", 0); pop(d2_done);
    rst_n = 1;
    tick();
    push("ar_post_busy", 0); push("ar_post_done", 0);
    pop(d2_busy); pop(d2_done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
